// File: rtl/shot_clock_controller.sv
// Basketball shot-clock sequencer: once-per-second countdown with start/stop,
// 24 s / 14 s reloads and a timed expiry buzzer. All outputs are registered.
module shot_clock_controller #(
    parameter int TICK_DIV    = 50000000,
    parameter int FULL_VALUE  = 24,
    parameter int SHORT_VALUE = 14,
    parameter int BUZZ_CYCLES = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       reload_full,
    input  logic       reload_short,
    output logic [4:0] count,
    output logic       running,
    output logic       expired,
    output logic       buzzer
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int BW = $clog2(BUZZ_CYCLES + 1);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BUZZ_MAX  = BW'(BUZZ_CYCLES - 1);
    localparam logic [4:0]    FULL_VAL  = 5'(FULL_VALUE);
    localparam logic [4:0]    SHORT_VAL = 5'(SHORT_VALUE);

    typedef enum logic [1:0] {
        STOPPED = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [4:0]      count_reg, count_next;
    logic [PW-1:0]   presc_reg, presc_next;
    logic            buzzer_reg, buzzer_next;
    logic [BW-1:0]   buzz_cnt_reg, buzz_cnt_next;

    // Bit order: 0=start, 1=stop, 2=reload_short, 3=reload_full
    logic [3:0] ctrl;
    logic [3:0] ctrl_d_reg;
    logic [3:0] ev;

    assign ctrl = {reload_full, reload_short, stop, start};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_edge
            assign ev[gi] = ctrl[gi] & ~ctrl_d_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= STOPPED;
            count_reg    <= FULL_VAL;
            presc_reg    <= '0;
            buzzer_reg   <= 1'b0;
            buzz_cnt_reg <= '0;
            ctrl_d_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            presc_reg    <= presc_next;
            buzzer_reg   <= buzzer_next;
            buzz_cnt_reg <= buzz_cnt_next;
            ctrl_d_reg   <= ctrl;
        end
    end

    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        presc_next    = presc_reg;
        buzzer_next   = buzzer_reg;
        buzz_cnt_next = buzz_cnt_reg;

        // Free-running behaviour of each state, overridden by events below
        case (state_reg)
            RUN: begin
                if (presc_reg == PRESC_MAX) begin
                    presc_next = '0;
                    if (count_reg <= 5'd1) begin
                        count_next    = 5'd0;
                        state_next    = EXPIRED;
                        buzzer_next   = 1'b1;
                        buzz_cnt_next = '0;
                    end else begin
                        count_next = count_reg - 5'd1;
                    end
                end else begin
                    presc_next = presc_reg + 1'b1;
                end
            end
            EXPIRED: begin
                if (buzzer_reg) begin
                    if (buzz_cnt_reg == BUZZ_MAX) begin
                        buzzer_next = 1'b0;
                    end else begin
                        buzz_cnt_next = buzz_cnt_reg + 1'b1;
                    end
                end
            end
            default: ;
        endcase

        if (ev[3] || ev[2]) begin
            count_next    = ev[3] ? FULL_VAL : SHORT_VAL;
            presc_next    = '0;
            buzzer_next   = 1'b0;
            buzz_cnt_next = '0;
            state_next    = (state_reg == RUN) ? RUN : STOPPED;
        end else if (ev[1]) begin
            // Pausing keeps the partial second; a stop edge also masks start
            if (state_reg == RUN) begin
                state_next    = STOPPED;
                count_next    = count_reg;
                presc_next    = presc_reg;
                buzzer_next   = buzzer_reg;
                buzz_cnt_next = buzz_cnt_reg;
            end
        end else if (ev[0] && state_reg == STOPPED && count_reg != 5'd0) begin
            state_next = RUN;
        end
    end

    assign count   = count_reg;
    assign running = (state_reg == RUN);
    assign expired = (state_reg == EXPIRED);
    assign buzzer  = buzzer_reg;

endmodule

// File: tb/tb_shot_clock_controller.sv
// Directed bench for shot_clock_controller with short tick and buzz periods.
module tb_shot_clock_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, stop, reload_full, reload_short;
    logic [4:0] count;
    logic       running, expired, buzzer;

    int checks = 0;
    int errors = 0;

    shot_clock_controller #(
        .TICK_DIV(4),
        .FULL_VALUE(24),
        .SHORT_VALUE(14),
        .BUZZ_CYCLES(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .stop(stop),
        .reload_full(reload_full),
        .reload_short(reload_short),
        .count(count),
        .running(running),
        .expired(expired),
        .buzzer(buzzer)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp_val);
        checks++;
        if (obs != exp_val) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, obs, exp_val, $time);
        end else begin
            $display("ok   %s = %0d", tag, obs);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input int c, input int r, input int e, input int b);
        chk({tag, ".count"}, count, c);
        chk({tag, ".running"}, running, r);
        chk({tag, ".expired"}, expired, e);
        chk({tag, ".buzzer"}, buzzer, b);
    endtask

    initial begin
        reset = 1'b1; start = 0; stop = 0; reload_full = 0; reload_short = 0;
        step(3);
        reset = 1'b0;
        chk_state("reset", 24, 0, 0, 0);

        for (int i = 0; i < 100; i++) begin
            step(1);
            chk("idle.count", count, 24);
            chk("idle.flags", {running, expired, buzzer}, 0);
        end

        // Full countdown to expiry
        start = 1; step(1); start = 0;
        chk_state("start", 24, 1, 0, 0);
        step(3);  chk("pre_tick.count", count, 24);
        step(1);  chk("first_tick.count", count, 23);
        step(91); chk("last_sec.count", count, 1);
        step(1);  chk_state("expiry", 0, 0, 1, 1);
        for (int i = 0; i < 7; i++) begin
            step(1);
            chk("buzz_high", buzzer, 1);
        end
        step(1); chk_state("buzz_done", 0, 0, 1, 0);

        start = 1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk_state("start_held_expired", 0, 0, 1, 0);
        end
        start = 0;

        // Reload out of EXPIRED, then pause with a partial second
        reload_full = 1; step(1); reload_full = 0;
        chk_state("reload_from_expired", 24, 0, 0, 0);
        start = 1; step(1); start = 0;
        chk("restart.running", running, 1);
        step(56); chk("at_ten.count", count, 10);
        step(2);
        stop = 1; step(1); stop = 0;
        chk_state("stopped_at_ten", 10, 0, 0, 0);
        step(50); chk_state("held_ten", 10, 0, 0, 0);
        start = 1; step(1); start = 0;
        chk_state("resume", 10, 1, 0, 0);
        step(1); chk("resume_plus1.count", count, 10);
        step(1); chk("resume_plus2.count", count, 9);

        // Short reload while running
        step(16); chk("at_five.count", count, 5);
        reload_short = 1; step(1); reload_short = 0;
        chk_state("short_reload_run", 14, 1, 0, 0);
        step(3); chk("short_pre_tick.count", count, 14);
        step(1); chk("short_tick.count", count, 13);
        stop = 1; step(1); stop = 0;
        chk("stop13.running", running, 0);
        start = 1; step(1); start = 0;
        step(24); chk("at_seven.count", count, 7);
        stop = 1; step(1); stop = 0;
        chk_state("stopped_seven", 7, 0, 0, 0);
        reload_full = 1; step(1); reload_full = 0;
        chk_state("full_reload_stopped", 24, 0, 0, 0);

        // Simultaneous edges
        reload_short = 1; step(1); reload_short = 0;
        chk("short_stopped.count", count, 14);
        reload_full = 1; reload_short = 1; step(1); reload_full = 0; reload_short = 0;
        chk_state("both_reloads", 24, 0, 0, 0);
        start = 1; stop = 1; step(1); start = 0; stop = 0;
        chk_state("start_stop_same", 24, 0, 0, 0);
        step(5); chk_state("start_stop_after", 24, 0, 0, 0);

        // Reset during buzzer window
        start = 1; step(1); start = 0;
        chk("run2.running", running, 1);
        step(96); chk_state("expiry2", 0, 0, 1, 1);
        step(3); chk("mid_buzz", buzzer, 1);
        reset = 1; step(1); reset = 0;
        chk_state("reset_mid_buzz", 24, 0, 0, 0);
        step(2);
        start = 1; step(1); start = 0;
        chk("post_reset_start.running", running, 1);
        step(4); chk("post_reset_tick.count", count, 23);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shot_clock_controller.md
Name: shot_clock_controller

Overview:
- Sequencing controller for the basketball shot clock: holds the 5-bit shot-clock value, decrements it once per second while running, and handles start/stop, the 24 s and 14 s reloads, and the expiry buzzer.
- count drives the existing 5-bit to dual seven-segment decoder directly (value range 0-31).
- Sits between the debounced DE10-Lite switch/key inputs and the display decoder.

Parameters:
- TICK_DIV, 50000000, clk cycles per 1 s decrement tick; minimum 2; the bench uses 4.
- FULL_VALUE, 24, full reload value in seconds; must be 1-31.
- SHORT_VALUE, 14, short reload value in seconds; must be 1-31.
- BUZZ_CYCLES, 50000000, number of cycles buzzer stays high after expiry; minimum 1.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high reset.
- start  in  1  level input, pre-synchronized and debounced; rising edge requests run.
- stop  in  1  level input, pre-synchronized; rising edge requests pause.
- reload_full  in  1  level input, pre-synchronized; rising edge loads FULL_VALUE.
- reload_short  in  1  level input, pre-synchronized; rising edge loads SHORT_VALUE.
- count  out  5  current shot-clock seconds, feeds the display decoder.
- running  out  1  high in RUN state.
- expired  out  1  high in EXPIRED state.
- buzzer  out  1  expiry horn drive.

Behaviour:
- Single clock. Synchronous active-high reset. All outputs are registered.
- Reset values: count=FULL_VALUE, state=STOPPED, prescaler=0, buzzer=0, buzz counter=0, edge-detect history registers=0.
- Edge detect: each control input is compared with its registered previous value. An event is a 0->1 transition, which acts exactly once, in the cycle after the rising level is sampled. Holding a level high has no further effect.
- States:
  - STOPPED: count frozen, prescaler frozen.
  - RUN: prescaler increments each cycle. When it reaches TICK_DIV-1 it wraps to 0 and count decrements in the same cycle.
  - EXPIRED: count=0, prescaler frozen.
- Event priority, evaluated every cycle: reload_full > reload_short > stop > start.
- Reload (either):
  - count <- value, prescaler <- 0, buzzer <- 0, buzz counter <- 0.
  - RUN stays RUN; STOPPED stays STOPPED; EXPIRED -> STOPPED.
  - The first decrement after a reload in RUN occurs exactly TICK_DIV cycles after the reload cycle.
  - A reload suppresses any tick or stop/start event in the same cycle.
- stop: RUN -> STOPPED. Prescaler keeps its value, so the fractional second is retained. Ignored in other states.
- start: STOPPED -> RUN when count>0. Ignored in RUN and EXPIRED.
- Simultaneous start and stop edges: stop wins, so the block is STOPPED afterwards.
- Expiry:
  - A tick in RUN with count==1 sets count=0, state=EXPIRED, and buzzer=1 on the same clock edge.
  - buzzer stays high for exactly BUZZ_CYCLES cycles, then drops to 0 and stays 0 while EXPIRED.
  - count never wraps below 0.
- running and expired are decoded from the registered state and update on the same edge as the state change.
- Reset mid-operation (including mid-buzz) returns every output to its reset value on the next edge; pending edges are discarded.

Test Plan:
- Reset, then idle for 100 cycles -> count=24, running=0, expired=0, buzzer=0 throughout.
- TICK_DIV=4, BUZZ_CYCLES=8: start pulse -> running=1; count reads 23 four cycles after the start edge is registered and reaches 0 ninety-six cycles after it. Then expired=1, running=0, and buzzer is high for exactly 8 cycles before dropping to 0.
- Run to count=10 with prescaler=2, then stop edge -> count holds 10 for 50 cycles. Start edge -> count becomes 9 exactly 2 cycles after re-entering RUN.
- reload_short edge while RUN at count=5 -> count=14 next cycle, still running, count=13 four cycles later. reload_full edge while STOPPED at 7 -> count=24, remains stopped.
- reload_full and reload_short rising in the same cycle -> count=24. Simultaneous start and stop edges in STOPPED -> remains STOPPED. start held high after expiry -> stays EXPIRED with count=0.
- Reset asserted for 1 cycle during the buzzer window -> next cycle: buzzer=0, count=24, STOPPED. A later start edge resumes a normal countdown.
